adc_sampler: RTL and testbench
==============================

# adc_sampler

Periodic sample sequencer for the front-end ADC (MCP3008-style, 10-bit, single-ended). It sits directly upstream of the SPI master and issues one 24-bit SPI frame per sample period. It also unpacks the returned frame into a channel-tagged 10-bit sample for the downstream filter chain. It flags overruns, timeouts and malformed frames so that dropped ECG samples are visible.

## Interface
- SAMPLE_PERIOD, 100000: clk_in cycles between sample starts (1 kHz at 100 MHz); must be ≥ 2.
- TIMEOUT_CYCLES, 8192: maximum cycles spent waiting for an SPI completion.
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  run sampling while high.
- channel_in  input  3  ADC channel; latched at each frame start.
- spi_data_out  output  24  frame to SPI master; held stable between frame starts.
- spi_trigger_out  output  1  one-cycle start pulse to SPI master.
- spi_data_in  input  24  frame received from SPI master.
- spi_valid_in  input  1  one-cycle completion pulse from SPI master.
- sample_out  output  10  latest conversion result.
- sample_ch_out  output  3  channel of sample_out.
- sample_valid_out  output  1  one-cycle pulse; sample_out/sample_ch_out valid.
- timeout_out  output  1  one-cycle pulse on SPI timeout.
- frame_err_out  output  1  one-cycle pulse on null-bit violation.
- overrun_count_out  output  8  saturating count of skipped periods.

## Operation
- Period counter `pcnt` (width $clog2(SAMPLE_PERIOD)):
  - While enable_in is low, it is held at SAMPLE_PERIOD-1.
  - Otherwise it counts up and wraps to 0 after SAMPLE_PERIOD-1.
  - `tick` = enable_in && pcnt == SAMPLE_PERIOD-1.
  - So the first tick occurs on the first enabled cycle.
- FSM states: IDLE, WAIT, REQ, BUSY, DONE.
  - IDLE: go to WAIT when enable_in is high.
  - WAIT: on tick, latch channel_in into ch_q, set spi_data_out = {8'h01, 1'b1, ch_q, 4'h0, 8'h00}, and go to REQ. If enable_in is low, go to IDLE.
  - REQ: spi_trigger_out = 1 for exactly this cycle. Clear the timeout counter and go to BUSY.
  - BUSY: if spi_valid_in is high, capture spi_data_in and go to DONE. Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1, pulse timeout_out and go to WAIT (or IDLE if enable_in is low).
  - DONE: process the captured frame.
    - If bit 10 is 0: sample_out = frame[9:0], sample_ch_out = ch_q, pulse sample_valid_out.
    - If bit 10 is 1: pulse frame_err_out; sample_out and sample_ch_out are unchanged.
    - Then go to WAIT if enable_in is high, else IDLE.
- A tick while in REQ, BUSY or DONE skips that period: overrun_count_out increments, saturating at 255. No queued request is made.
- Deasserting enable_in mid-frame does not abort the frame. BUSY runs to completion or timeout, DONE reports normally, then the FSM goes to IDLE.
- spi_valid_in outside BUSY is ignored.
- overrun_count_out is cleared only by reset.

## Timing
- Reset (rst_in low, asynchronous):
  - State = IDLE, pcnt = SAMPLE_PERIOD-1.
  - All outputs 0, including spi_data_out = 24'h0 and overrun_count_out = 0.
  - Release is synchronous to clk_in.
  - Reset mid-frame discards the frame; the late spi_valid_in is ignored.
- Tick at cycle T (in WAIT): spi_trigger_out is high at T+1, and spi_data_out is already valid at T+1.
- spi_valid_in seen at cycle C (in BUSY): sample_valid_out or frame_err_out is high at C+2 (one cycle to DONE, registered output).
- At most one trigger per SAMPLE_PERIOD. All pulse outputs are exactly one cycle wide.
- Simultaneous events in BUSY:
  - spi_valid_in on the same cycle as the timeout limit: spi_valid_in wins, with no timeout pulse.
  - A tick on the same cycle: the period is counted as an overrun.

## Test plan
- Reset, then enable with SAMPLE_PERIOD=50, channel_in=3, and an SPI model returning 24'h0002A5 after 20 cycles → trigger at first enabled cycle+1 with spi_data_out=24'h01B000; sample_out=10'h2A5, sample_ch_out=3, and sample_valid_out for 1 cycle; next trigger exactly 50 cycles after the first.
- SPI model returns 24'h000600 (bit 10 set) → frame_err_out pulses; sample_out keeps its previous value; no sample_valid_out.
- TIMEOUT_CYCLES=40, SPI model never responds → timeout_out pulses 40 cycles after trigger; next trigger occurs on the following tick.
- SAMPLE_PERIOD=50, SPI latency 120 cycles → overrun_count_out increments on each tick while busy (2 per frame); it saturates at 255 after a long run.
- Drop enable_in mid-BUSY → the frame completes and sample_valid_out pulses once; no further triggers; re-enabling triggers on the next cycle+1.
- Assert rst_in low mid-BUSY, then deliver a late spi_valid_in → all outputs are 0 and no sample_valid_out is produced.

Source files
------------

// File: rtl/adc_sampler.sv
// adc_sampler: periodic MCP3008-style sample sequencer in front of the SPI master.
// Issues one 24-bit frame per sample period and unpacks the channel-tagged 10-bit result.
module adc_sampler #(
  parameter int SAMPLE_PERIOD  = 100000,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [2:0]  channel_in,
  output logic [23:0] spi_data_out,
  output logic        spi_trigger_out,
  input  logic [23:0] spi_data_in,
  input  logic        spi_valid_in,
  output logic [9:0]  sample_out,
  output logic [2:0]  sample_ch_out,
  output logic        sample_valid_out,
  output logic        timeout_out,
  output logic        frame_err_out,
  output logic [7:0]  overrun_count_out
);

  // state | meaning
  // IDLE  | sampling disabled, period counter parked
  // WAIT  | enabled, waiting for the next period tick
  // REQ   | one-cycle SPI start pulse, timeout counter cleared
  // BUSY  | waiting for SPI completion or timeout
  // DONE  | unpack captured frame, report sample or null-bit error

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic          tick;
  logic          in_frame;
  logic          start;
  logic          capture;
  logic          timeout_nxt;
  logic          sample_valid_nxt;
  logic          frame_err_nxt;
  logic [2:0]    ch_q;
  logic [10:0]   frame_q;
  logic          unused_frame_hi;

  // Only the null bit and the 10 result bits of the returned frame carry information.
  assign unused_frame_hi = ^spi_data_in[23:11];

  assign tick     = enable_in && (pcnt == PCNT_LAST);
  assign in_frame = (state == ST_REQ) || (state == ST_BUSY) || (state == ST_DONE);
  assign tcnt_inc = tcnt + TW'(1);

  // Parked at the last count while disabled so the first enabled cycle ticks.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pcnt <= PCNT_LAST;
    end else if (!enable_in) begin
      pcnt <= PCNT_LAST;
    end else if (pcnt == PCNT_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    tcnt_nxt         = tcnt;
    start            = 1'b0;
    capture          = 1'b0;
    timeout_nxt      = 1'b0;
    sample_valid_nxt = 1'b0;
    frame_err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_in) begin
          if (tick) begin
            start     = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!enable_in) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          start     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        tcnt_nxt  = '0;
        state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        // A completion on the limit cycle wins over the timeout.
        if (spi_valid_in) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (tcnt_inc == TCNT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = enable_in ? ST_WAIT : ST_IDLE;
        end else begin
          tcnt_nxt = tcnt_inc;
        end
      end
      ST_DONE: begin
        if (frame_q[10]) begin
          frame_err_nxt = 1'b1;
        end else begin
          sample_valid_nxt = 1'b1;
        end
        state_nxt = enable_in ? ST_WAIT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      spi_trigger_out   <= 1'b0;
      spi_data_out      <= '0;
      ch_q              <= '0;
      frame_q           <= '0;
      sample_out        <= '0;
      sample_ch_out     <= '0;
      sample_valid_out  <= 1'b0;
      timeout_out       <= 1'b0;
      frame_err_out     <= 1'b0;
      overrun_count_out <= '0;
    end else begin
      spi_trigger_out  <= (state_nxt == ST_REQ);
      timeout_out      <= timeout_nxt;
      sample_valid_out <= sample_valid_nxt;
      frame_err_out    <= frame_err_nxt;
      if (start) begin
        ch_q         <= channel_in;
        spi_data_out <= {8'h01, 1'b1, channel_in, 4'h0, 8'h00};
      end
      if (capture) begin
        frame_q <= spi_data_in[10:0];
      end
      if (sample_valid_nxt) begin
        sample_out    <= frame_q[9:0];
        sample_ch_out <= ch_q;
      end
      // A period that starts while a frame is still in flight is dropped, not queued.
      if (tick && in_frame && (overrun_count_out != 8'hFF)) begin
        overrun_count_out <= overrun_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: instance a (period 50, long timeout), instance b (period 50, timeout 40).
module tb_adc_sampler;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [2:0]  ch_a, ch_b;
  logic [23:0] sd_a, sd_b;
  logic        sv_a, sv_b;
  logic [23:0] a_data, b_data;
  logic        a_trig, b_trig;
  logic [9:0]  a_smp, b_smp;
  logic [2:0]  a_sch, b_sch;
  logic        a_sv, b_sv, a_to, b_to, a_fe, b_fe;
  logic [7:0]  a_ovr, b_ovr;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  adc_sampler #(.SAMPLE_PERIOD(50), .TIMEOUT_CYCLES(8192)) dut_a (
    .clk_in(clk_in), .rst_in(rst_n), .enable_in(en_a), .channel_in(ch_a),
    .spi_data_out(a_data), .spi_trigger_out(a_trig), .spi_data_in(sd_a), .spi_valid_in(sv_a),
    .sample_out(a_smp), .sample_ch_out(a_sch), .sample_valid_out(a_sv),
    .timeout_out(a_to), .frame_err_out(a_fe), .overrun_count_out(a_ovr)
  );

  adc_sampler #(.SAMPLE_PERIOD(50), .TIMEOUT_CYCLES(40)) dut_b (
    .clk_in(clk_in), .rst_in(rst_n), .enable_in(en_b), .channel_in(ch_b),
    .spi_data_out(b_data), .spi_trigger_out(b_trig), .spi_data_in(sd_b), .spi_valid_in(sv_b),
    .sample_out(b_smp), .sample_ch_out(b_sch), .sample_valid_out(b_sv),
    .timeout_out(b_to), .frame_err_out(b_fe), .overrun_count_out(b_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_trig_a(input string tag);
    int n;
    n = 0;
    while (a_trig !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    chk(tag, 32'(a_trig), 32'd1);
  endtask

  initial begin
    int n_trig;
    int n_sv;
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    ch_a = 3'd0; ch_b = 3'd0;
    sd_a = '0;   sd_b = '0;
    sv_a = 1'b0; sv_b = 1'b0;

    step(3);
    chk("rst_data",    32'(a_data), 32'h0);
    chk("rst_trig",    32'(a_trig), 32'h0);
    chk("rst_sample",  32'(a_smp),  32'h0);
    chk("rst_ch",      32'(a_sch),  32'h0);
    chk("rst_valid",   32'(a_sv),   32'h0);
    chk("rst_timeout", 32'(a_to),   32'h0);
    chk("rst_ferr",    32'(a_fe),   32'h0);
    chk("rst_ovr",     32'(a_ovr),  32'h0);
    rst_n = 1'b1;
    step(2);
    chk("idle_no_trig", 32'(a_trig), 32'h0);

    // first frame: enable at cycle E, trigger at E+1, response after 20 cycles
    ch_a = 3'd3; en_a = 1'b1;
    step(1);
    chk("first_trig", 32'(a_trig), 32'd1);
    chk("first_data", 32'(a_data), 32'h01B000);
    step(1);
    chk("trig_one_cycle", 32'(a_trig), 32'd0);
    step(19);
    sd_a = 24'h0002A5; sv_a = 1'b1;
    step(1);
    sv_a = 1'b0;
    chk("sv_not_early", 32'(a_sv), 32'd0);
    step(1);
    chk("sv_pulse",  32'(a_sv),  32'd1);
    chk("sample",    32'(a_smp), 32'h2A5);
    chk("sample_ch", 32'(a_sch), 32'd3);
    step(1);
    chk("sv_one_cycle", 32'(a_sv), 32'd0);
    step(26);
    chk("no_trig_before_period", 32'(a_trig), 32'd0);
    step(1);
    chk("second_trig", 32'(a_trig), 32'd1);

    // null bit set in the returned frame
    step(20);
    sd_a = 24'h000600; sv_a = 1'b1;
    step(1);
    sv_a = 1'b0;
    step(1);
    chk("ferr_pulse",     32'(a_fe),  32'd1);
    chk("ferr_no_sv",     32'(a_sv),  32'd0);
    chk("ferr_keep_smp",  32'(a_smp), 32'h2A5);
    step(1);
    chk("ferr_one_cycle", 32'(a_fe),  32'd0);

    // completion pulse while waiting for the next tick is ignored
    step(7);
    sd_a = 24'h000001; sv_a = 1'b1;
    step(1);
    sv_a = 1'b0;
    step(1);
    chk("stray_valid_sv",   32'(a_sv),  32'd0);
    chk("stray_valid_ferr", 32'(a_fe),  32'd0);
    chk("stray_valid_smp",  32'(a_smp), 32'h2A5);

    // drop enable mid-BUSY: frame still completes, then no more triggers
    step(18);
    chk("third_trig", 32'(a_trig), 32'd1);
    step(5);
    en_a = 1'b0;
    step(15);
    sd_a = 24'h000155; sv_a = 1'b1;
    step(1);
    sv_a = 1'b0;
    step(1);
    chk("drop_en_sv",     32'(a_sv),  32'd1);
    chk("drop_en_sample", 32'(a_smp), 32'h155);
    n_trig = 0; n_sv = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (a_trig) n_trig++;
      if (a_sv) n_sv++;
    end
    chk("disabled_no_trig", 32'(n_trig), 32'd0);
    chk("disabled_no_sv",   32'(n_sv),   32'd0);

    // re-enable on channel 5, then slow SPI (120 cycles) to force overruns
    ch_a = 3'd5; en_a = 1'b1;
    step(1);
    chk("reen_trig", 32'(a_trig), 32'd1);
    chk("reen_data", 32'(a_data), 32'h01D000);
    chk("ovr_zero",  32'(a_ovr),  32'd0);
    step(49);
    chk("ovr_before_tick", 32'(a_ovr), 32'd0);
    step(1);
    chk("ovr_one", 32'(a_ovr), 32'd1);
    step(50);
    chk("ovr_two", 32'(a_ovr), 32'd2);
    step(20);
    sd_a = 24'h00003C; sv_a = 1'b1;
    step(1);
    sv_a = 1'b0;
    step(1);
    chk("slow_sv",     32'(a_sv),  32'd1);
    chk("slow_sample", 32'(a_smp), 32'h03C);
    chk("slow_ch",     32'(a_sch), 32'd5);
    step(28);
    chk("slow_next_trig", 32'(a_trig), 32'd1);

    for (int f = 0; f < 126; f++) begin
      wait_trig_a("loop_trig");
      step(120);
      sd_a = 24'h000011; sv_a = 1'b1;
      step(1);
      sv_a = 1'b0;
    end
    chk("ovr_254", 32'(a_ovr), 32'd254);
    for (int f = 0; f < 2; f++) begin
      wait_trig_a("sat_trig");
      step(120);
      sd_a = 24'h000011; sv_a = 1'b1;
      step(1);
      sv_a = 1'b0;
    end
    chk("ovr_saturated", 32'(a_ovr), 32'd255);
    en_a = 1'b0;

    // timeout on instance b (limit 40)
    ch_b = 3'd6; en_b = 1'b1;
    step(1);
    chk("b_trig", 32'(b_trig), 32'd1);
    chk("b_data", 32'(b_data), 32'h01E000);
    step(39);
    chk("to_not_early", 32'(b_to), 32'd0);
    step(1);
    chk("to_pulse", 32'(b_to), 32'd1);
    step(1);
    chk("to_one_cycle", 32'(b_to), 32'd0);
    step(8);
    chk("to_no_early_trig", 32'(b_trig), 32'd0);
    step(1);
    chk("to_next_trig", 32'(b_trig), 32'd1);
    chk("to_no_ovr",    32'(b_ovr),  32'd0);

    // completion on the timeout limit cycle wins
    step(39);
    sd_b = 24'h0003FF; sv_b = 1'b1;
    step(1);
    sv_b = 1'b0;
    chk("limit_no_to", 32'(b_to), 32'd0);
    step(1);
    chk("limit_sv",     32'(b_sv),  32'd1);
    chk("limit_sample", 32'(b_smp), 32'h3FF);
    chk("limit_ch",     32'(b_sch), 32'd6);

    // reset mid-BUSY, then a late completion
    step(9);
    chk("b_third_trig", 32'(b_trig), 32'd1);
    step(10);
    rst_n = 1'b0; en_b = 1'b0;
    #1;
    chk("midrst_data",   32'(b_data), 32'h0);
    chk("midrst_sample", 32'(b_smp),  32'h0);
    chk("midrst_ch",     32'(b_sch),  32'h0);
    chk("midrst_a_ovr",  32'(a_ovr),  32'h0);
    step(1);
    rst_n = 1'b1;
    step(2);
    sd_b = 24'h0000AA; sv_b = 1'b1;
    step(1);
    sv_b = 1'b0;
    n_sv = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (b_sv) n_sv++;
    end
    chk("late_valid_no_sv", 32'(n_sv),  32'd0);
    chk("late_valid_smp",   32'(b_smp), 32'h0);
    chk("late_valid_trig",  32'(b_trig), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
